// File: rtl/vga_rect_fill_ctrl_if.sv
// Bus bundle between the rectangle-fill controller and the VGA register window.
// Write channel: wr_addr, wr_data, wr_byteEn, wr_valid (master out), wr_ready (master in).
// Read channel:  rd_addr, rd_byteEn, rd_valid (master out), rd_ready, rd_data (master in).
interface vga_rect_fill_ctrl_if;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byteEn;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_addr;
  logic [3:0]  rd_byteEn;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (
    output wr_addr, wr_data, wr_byteEn, wr_valid,
    input  wr_ready,
    output rd_addr, rd_byteEn, rd_valid,
    input  rd_ready, rd_data
  );

  modport slave (
    input  wr_addr, wr_data, wr_byteEn, wr_valid,
    output wr_ready,
    input  rd_addr, rd_byteEn, rd_valid,
    output rd_ready, rd_data
  );
endinterface

// File: rtl/vga_rect_fill_ctrl.sv
// Rectangle fill controller for a VGA peripheral with an auto-incrementing pixel cursor.
// Each row is drawn as: write X, write Y, then w writes of the colour to DATA.
// Ports:
//   clock, reset       - single clock, synchronous active-high reset
//   cmd_valid/ready    - command handshake; cmd_x/y/w/h/color/vsync latched on accept
//   abort              - stop after the current row (sticky until the command ends)
//   busy, done         - command in progress / one-cycle end-of-command pulse
//   bus                - write and read master channels into the VGA register window
module vga_rect_fill_ctrl #(
  parameter logic [31:0] VGA_ADDR = 32'h1000_0000,
  parameter int unsigned MAX_W    = 640,
  parameter int unsigned MAX_H    = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [10:0] cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [23:0] cmd_color,
  input  logic        cmd_vsync,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  vga_rect_fill_ctrl_if.master bus
);

  localparam logic [11:0] MaxW     = 12'(MAX_W);
  localparam logic [11:0] MaxH     = 12'(MAX_H);
  localparam logic [31:0] AddrX    = VGA_ADDR + 32'h04;
  localparam logic [31:0] AddrY    = VGA_ADDR + 32'h08;
  localparam logic [31:0] AddrData = VGA_ADDR + 32'h0c;
  localparam logic [31:0] AddrScan = VGA_ADDR + 32'h1c;

  typedef enum logic [2:0] {
    StIdle, StVbWaitActive, StVbWaitBlank, StSetX, StSetY, StFill, StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [11:0] y_q, y_d, y_last_q, y_last_d, w_q, w_d, cnt_q, cnt_d;
  logic [23:0] color_q, color_d;
  logic        abort_q, abort_d, done_q, done_d;
  logic        wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
  logic [3:0]  byte_en_q, byte_en_d;

  // Clipping in 12 bits so x+w and y+h cannot wrap.
  logic [11:0] x_ext, y_ext, w_ext, h_ext, w_room, h_room, w_clip, h_clip;
  logic        abort_seen, scan_zero;
  logic        unused_rd_data;

  assign x_ext  = {1'b0, cmd_x};
  assign y_ext  = {2'b0, cmd_y};
  assign w_ext  = {1'b0, cmd_w};
  assign h_ext  = {2'b0, cmd_h};
  assign w_room = (x_ext >= MaxW) ? 12'd0 : MaxW - x_ext;
  assign h_room = (y_ext >= MaxH) ? 12'd0 : MaxH - y_ext;
  assign w_clip = (w_ext < w_room) ? w_ext : w_room;
  assign h_clip = (h_ext < h_room) ? h_ext : h_room;

  assign abort_seen     = abort_q | abort;
  assign scan_zero      = (bus.rd_data[9:0] == 10'd0);
  assign unused_rd_data = ^bus.rd_data[31:10];

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    y_last_d   = y_last_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    color_d    = color_q;
    abort_d    = abort_q | (abort & (state_q != StIdle));
    done_d     = 1'b0;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    byte_en_d  = byte_en_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          x_d      = cmd_x;
          y_d      = y_ext;
          y_last_d = y_ext + h_clip - 12'd1;
          w_d      = w_clip;
          color_d  = cmd_color;
          cnt_d    = 12'd0;
          if (w_clip == 12'd0 || h_clip == 12'd0) state_d = StFinish;
          else if (cmd_vsync)                     state_d = StVbWaitActive;
          else                                    state_d = StSetX;
        end
      end
      StVbWaitActive, StVbWaitBlank: begin
        if (!rd_valid_q) begin
          if (abort_seen) begin
            state_d = StFinish;
          end else begin
            rd_valid_d = 1'b1;
            rd_addr_d  = AddrScan;
            byte_en_d  = 4'hF;
          end
        end else if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (abort_seen)                                 state_d = StFinish;
          else if (state_q == StVbWaitActive && !scan_zero) state_d = StVbWaitBlank;
          else if (state_q == StVbWaitBlank && scan_zero)   state_d = StSetX;
        end
      end
      StSetX, StSetY, StFill: begin
        if (!wr_valid_q) begin
          wr_valid_d = 1'b1;
          byte_en_d  = 4'hF;
          if (state_q == StSetX) begin
            wr_addr_d = AddrX;
            wr_data_d = {21'd0, x_q};
          end else if (state_q == StSetY) begin
            wr_addr_d = AddrY;
            wr_data_d = {20'd0, y_q};
          end else begin
            wr_addr_d = AddrData;
            wr_data_d = {8'd0, color_q};
          end
        end else if (bus.wr_ready) begin
          wr_valid_d = 1'b0;
          if (state_q == StSetX) begin
            state_d = StSetY;
          end else if (state_q == StSetY) begin
            cnt_d   = 12'd0;
            state_d = StFill;
          end else if (cnt_q == w_q - 12'd1) begin
            // Abort only takes effect once the row in flight is complete.
            if (abort_seen || y_q == y_last_q) begin
              state_d = StFinish;
            end else begin
              y_d     = y_q + 12'd1;
              state_d = StSetX;
            end
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      StFinish: begin
        // done is registered, so the pulse appears in the cycle after FINISH.
        done_d  = 1'b1;
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= 11'd0;
      y_q        <= 12'd0;
      y_last_q   <= 12'd0;
      w_q        <= 12'd0;
      cnt_q      <= 12'd0;
      color_q    <= 24'd0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= 32'd0;
      byte_en_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      y_last_q   <= y_last_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      byte_en_q  <= byte_en_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_byteEn = byte_en_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_byteEn = byte_en_q;

endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
module tb_vga_rect_fill_ctrl;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          MAX_W = 640;
  localparam int          MAX_H = 480;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_vsync, abort, busy, done;
  logic [10:0] cmd_x, cmd_w;
  logic [9:0]  cmd_y, cmd_h;
  logic [23:0] cmd_color;

  vga_rect_fill_ctrl_if bus ();

  vga_rect_fill_ctrl #(.VGA_ADDR(BASE), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .cmd_vsync (cmd_vsync),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial forever #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int scan_q[$];
  int stall_min, stall_max, w_stall, r_stall, w_wait, r_wait;
  int rd_cnt, wr_first_rd;
  bit hs_w, hs_r;

  // Reference: the write sequence a clipped, possibly row-limited fill must produce.
  task automatic build_exp(input int x, y, w, h, c, rows_lim);
    int we, he;
    we = (x >= MAX_W) ? 0 : ((w < MAX_W - x) ? w : MAX_W - x);
    he = (y >= MAX_H) ? 0 : ((h < MAX_H - y) ? h : MAX_H - y);
    if (we == 0) he = 0;
    for (int r = 0; r < he && r < rows_lim; r++) begin
      exp_q.push_back({BASE + 32'h4, 32'(x)});
      exp_q.push_back({BASE + 32'h8, 32'(y + r)});
      for (int i = 0; i < we; i++) exp_q.push_back({BASE + 32'hc, 32'(c)});
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [63:0] entry(input bit from_got, input int i);
    if (from_got) return (i < got_q.size()) ? got_q[i] : 64'd0;
    return (i < exp_q.size()) ? exp_q[i] : 64'd0;
  endfunction

  task automatic prep(input int smin, smax);
    got_q.delete();
    exp_q.delete();
    scan_q.delete();
    rd_cnt      = 0;
    wr_first_rd = -1;
    stall_min   = smin;
    stall_max   = smax;
    w_stall     = $urandom_range(smax, smin);
    r_stall     = $urandom_range(smax, smin);
  endtask

  // Issues one command and watches it to completion (bounded); abort is pulsed once
  // when abort_at writes have been granted or at cycle abort_cyc.
  task automatic run_cmd(input int x, y, w, h, c, input bit vs, input int abort_at, abort_cyc,
                         output int done_cnt, output int done_k, output bit wv_seen);
    int ab_state;
    ab_state = 0;
    done_cnt = 0;
    done_k   = -1;
    wv_seen  = 0;
    @(negedge clock);
    cmd_x = 11'(x); cmd_y = 10'(y); cmd_w = 11'(w); cmd_h = 10'(h);
    cmd_color = 24'(c); cmd_vsync = vs; cmd_valid = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clock);
      if (k == 1) cmd_valid = 1'b0;
      if (bus.wr_valid) wv_seen = 1;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (ab_state == 1) begin
        abort = 1'b0;
        ab_state = 2;
      end else if (ab_state == 0 &&
                   ((abort_at >= 0 && got_q.size() >= abort_at) || k == abort_cyc)) begin
        abort = 1'b1;
        ab_state = 1;
      end
      if (done_k > 0 && k >= done_k + 3) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, bus.wr_valid, bus.rd_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/wr_valid/rd_valid=%b want 0000",
               {busy, done, bus.wr_valid, bus.rd_valid});
    end
    checks++;
    if ({bus.wr_addr, bus.wr_data, bus.rd_addr, bus.wr_byteEn, bus.rd_byteEn} !== 104'd0) begin
      errors++;
      $display("FAIL reset_bus: wr_addr=%h wr_data=%h rd_addr=%h be=%h/%h want all 0",
               bus.wr_addr, bus.wr_data, bus.rd_addr, bus.wr_byteEn, bus.rd_byteEn);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready/busy/done=%b want 100", {cmd_ready, busy, done});
    end
  endtask

  task automatic test_basic();
    int dc, dk, d;
    bit wv;
    prep(1, 1);
    build_exp(10, 20, 3, 2, 5, 99);
    run_cmd(10, 20, 3, 2, 5, 0, -1, -1, dc, dk, wv);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL basic_log: at %0d got %h want %h (%0d/%0d entries)", d, entry(1, d),
               entry(0, d), got_q.size(), exp_q.size());
    end
    checks++;
    if (dc != 1) begin
      errors++;
      $display("FAIL basic_done: done pulses=%0d want 1", dc);
    end
  endtask

  task automatic test_zero_size();
    int dc, dk;
    bit wv;
    prep(0, 1);
    run_cmd(3, 4, 0, 7, 'h55, 0, -1, -1, dc, dk, wv);
    checks++;
    if (dc != 1 || dk != 2) begin
      errors++;
      $display("FAIL zero_done: pulses=%0d at cycle %0d want 1 at 2", dc, dk);
    end
    checks++;
    if (wv || got_q.size() != 0) begin
      errors++;
      $display("FAIL zero_bus: wr_valid seen=%0d writes=%0d want 0/0", wv, got_q.size());
    end
    // Origin outside the frame is a zero-size fill.
    prep(0, 1);
    run_cmd(700, 4, 5, 2, 'h55, 0, -1, -1, dc, dk, wv);
    checks++;
    if (dc != 1 || wv) begin
      errors++;
      $display("FAIL zero_offframe: pulses=%0d wr_valid seen=%0d want 1/0", dc, wv);
    end
  endtask

  task automatic test_clip();
    int dc, dk, d, nd;
    bit wv;
    prep(0, 2);
    build_exp(638, 7, 10, 1, 'h0a0b0c, 99);
    run_cmd(638, 7, 10, 1, 'h0a0b0c, 0, -1, -1, dc, dk, wv);
    nd = 0;
    foreach (got_q[i]) if (got_q[i][63:32] == BASE + 32'hc) nd++;
    checks++;
    if (nd != 2 || dc != 1) begin
      errors++;
      $display("FAIL clip_x: data writes=%0d done=%0d want 2/1", nd, dc);
    end
    prep(0, 2);
    build_exp(100, 478, 2, 5, 'h33, 99);
    run_cmd(100, 478, 2, 5, 'h33, 0, -1, -1, dc, dk, wv);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL clip_y: at %0d got %h want %h (%0d/%0d entries)", d, entry(1, d),
               entry(0, d), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_vsync();
    int dc, dk, d;
    bit wv;
    prep(0, 1);
    scan_q = '{0, 0, 5, 6, 0};
    build_exp(2, 3, 2, 1, 'h77, 99);
    run_cmd(2, 3, 2, 1, 'h77, 1, -1, -1, dc, dk, wv);
    checks++;
    if (wr_first_rd != 5 || rd_cnt != 5) begin
      errors++;
      $display("FAIL vsync_order: reads before first write=%0d total reads=%0d want 5/5",
               wr_first_rd, rd_cnt);
    end
    d = first_diff();
    checks++;
    if (d >= 0 || dc != 1) begin
      errors++;
      $display("FAIL vsync_log: diff at %0d got %h want %h done=%0d", d, entry(1, d),
               entry(0, d), dc);
    end
  endtask

  task automatic test_abort();
    int dc, dk, d;
    bit wv;
    prep(5, 5);
    build_exp(0, 100, 3, 4, 'habcdef, 2);
    // 7 granted writes = all of row 0 plus X and Y of row 1.
    run_cmd(0, 100, 3, 4, 'habcdef, 0, 7, -1, dc, dk, wv);
    d = first_diff();
    checks++;
    if (d >= 0 || dc != 1) begin
      errors++;
      $display("FAIL abort_rows: diff at %0d got %h want %h (%0d/%0d entries) done=%0d", d,
               entry(1, d), entry(0, d), got_q.size(), exp_q.size(), dc);
    end
    // Abort while polling scanline (never leaves active video).
    prep(0, 1);
    run_cmd(1, 1, 2, 2, 'h7, 1, -1, 12, dc, dk, wv);
    checks++;
    if (dc != 1 || got_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL abort_vb: done=%0d writes=%0d busy=%0d want 1/0/0", dc, got_q.size(), busy);
    end
  endtask

  task automatic test_random();
    int x, y, w, h, c, dc, dk, d;
    bit wv;
    for (int n = 0; n < 8; n++) begin
      x = ($urandom_range(1, 0) == 1) ? $urandom_range(40, 0) : $urandom_range(660, 620);
      y = ($urandom_range(1, 0) == 1) ? $urandom_range(10, 0) : $urandom_range(490, 470);
      w = $urandom_range(12, 0);
      h = $urandom_range(4, 0);
      c = $urandom_range(32'h00ff_ffff, 0);
      prep(0, 2);
      build_exp(x, y, w, h, c, 99);
      run_cmd(x, y, w, h, c, 0, -1, -1, dc, dk, wv);
      d = first_diff();
      checks++;
      if (d >= 0 || dc != 1) begin
        errors++;
        $display("FAIL random_%0d: x=%0d y=%0d w=%0d h=%0d diff at %0d got %h want %h done=%0d",
                 n, x, y, w, h, d, entry(1, d), entry(0, d), dc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dn, d;
    bit held_ok, acc2;
    dn = 0;
    held_ok = 1;
    acc2 = 0;
    prep(0, 1);
    build_exp(5, 6, 4, 2, 'h111, 99);
    build_exp(30, 40, 2, 3, 'h222, 99);
    @(negedge clock);
    cmd_x = 5; cmd_y = 6; cmd_w = 4; cmd_h = 2; cmd_color = 'h111; cmd_vsync = 0;
    cmd_valid = 1'b1;
    @(negedge clock);
    // Second command offered for the whole duration of the first.
    cmd_x = 30; cmd_y = 40; cmd_w = 2; cmd_h = 3; cmd_color = 'h222;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (acc2) cmd_valid = 1'b0;
      if (done) dn++;
      if (dn == 0 && cmd_ready) held_ok = 0;
      if (cmd_valid && cmd_ready && dn >= 1) acc2 = 1;
      if (dn == 2) break;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!held_ok || dn != 2) begin
      errors++;
      $display("FAIL b2b_hold: held off=%0d done pulses=%0d want 1/2", held_ok, dn);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL b2b_log: at %0d got %h want %h (%0d/%0d entries)", d, entry(1, d),
               entry(0, d), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    prep(1000, 1000);
    @(negedge clock);
    cmd_x = 0; cmd_y = 0; cmd_w = 4; cmd_h = 1; cmd_color = 'h9; cmd_vsync = 0;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.wr_valid) seen = 1;
      else @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (!seen || {bus.wr_valid, bus.rd_valid, busy, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid: valid seen=%0d wr_valid/rd_valid/busy/cmd_ready=%b want 0001",
               seen, {bus.wr_valid, bus.rd_valid, busy, cmd_ready});
    end
    reset = 1'b0;
    @(negedge clock);
    prep(0, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; cmd_vsync = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    bus.wr_ready = 1'b0; bus.rd_ready = 1'b0; bus.rd_data = '0;
    w_wait = 0; r_wait = 0; hs_w = 0; hs_r = 0;
    prep(0, 0);

    // Slave model for the VGA register window: stalls, logs writes, serves scanlines.
    fork
      forever begin
        @(negedge clock);
        if (reset) begin
          bus.wr_ready = 1'b0; bus.rd_ready = 1'b0;
          w_wait = 0; r_wait = 0; hs_w = 0; hs_r = 0;
        end else begin
          if (bus.wr_valid || bus.rd_valid) begin
            checks++;
            if (bus.wr_valid && bus.rd_valid) begin
              errors++;
              $display("FAIL bus_overlap: wr_valid=1 rd_valid=1 want at most one");
            end
          end
          if (hs_w || hs_r) begin
            checks++;
            if ((hs_w && bus.wr_valid) || (hs_r && bus.rd_valid)) begin
              errors++;
              $display("FAIL valid_drop: wr_valid=%0d rd_valid=%0d after handshake want 0",
                       bus.wr_valid, bus.rd_valid);
            end
          end
          hs_w = 0;
          hs_r = 0;
          if (bus.wr_ready) bus.wr_ready = 1'b0;
          else if (bus.wr_valid) begin
            if (w_wait < w_stall) w_wait++;
            else begin
              bus.wr_ready = 1'b1; hs_w = 1; w_wait = 0;
              checks++;
              if (bus.wr_byteEn !== 4'hF) begin
                errors++;
                $display("FAIL wr_byteEn: got %h want f", bus.wr_byteEn);
              end
              got_q.push_back({bus.wr_addr, bus.wr_data});
              if (wr_first_rd < 0) wr_first_rd = rd_cnt;
              w_stall = $urandom_range(stall_max, stall_min);
            end
          end
          if (bus.rd_ready) bus.rd_ready = 1'b0;
          else if (bus.rd_valid) begin
            if (r_wait < r_stall) r_wait++;
            else begin
              bus.rd_ready = 1'b1; hs_r = 1; r_wait = 0;
              bus.rd_data = (scan_q.size() > 0) ? 32'(scan_q.pop_front()) : 32'd0;
              rd_cnt++;
              checks++;
              if ({bus.rd_addr, bus.rd_byteEn} !== {BASE + 32'h1c, 4'hF}) begin
                errors++;
                $display("FAIL rd_req: addr=%h be=%h want %h f", bus.rd_addr, bus.rd_byteEn,
                         BASE + 32'h1c);
              end
              r_stall = $urandom_range(stall_max, stall_min);
            end
          end
        end
      end
    join_none

    test_reset();
    test_basic();
    test_zero_size();
    test_clip();
    test_vsync();
    test_abort();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_rect_fill_ctrl.md
VGA_RECT_FILL_CTRL -- requirements
Module: vga_rect_fill_ctrl

Interface
REQ-001 SHALL have parameter VGA_ADDR, default 'h1000_0000, meaning the base address of the VGA peripheral register window (32 bytes).
REQ-002 SHALL have parameter MAX_W, default 640, meaning the logical frame width in pixels.
REQ-003 SHALL have parameter MAX_H, default 480, meaning the logical frame height in lines.
REQ-004 SHALL have port clock  in  1  the single clock; one clock, and all logic is clocked on its rising edge.
REQ-005 SHALL have port reset  in  1  the reset; synchronous and active-high.
REQ-006 SHALL have port cmd_valid  in  1  fill command offered.
REQ-007 SHALL have port cmd_ready  out  1  fill command accepted when high together with cmd_valid.
REQ-008 SHALL have ports cmd_x  in  11, cmd_y  in  10, cmd_w  in  11, cmd_h  in  10  giving the rectangle origin and size in logical pixels.
REQ-009 SHALL have port cmd_color  in  24  the pixel value written for every pixel (palette index or {B,G,R}).
REQ-010 SHALL have port cmd_vsync  in  1  when set, the first write waits for vertical blank.
REQ-011 SHALL have port abort  in  1  stops the fill at the next row boundary.
REQ-012 SHALL have port busy  out  1  high while a command is in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse when a command ends.
REQ-014 SHALL have write master ports wr_addr out 32, wr_data out 32, wr_byteEn out 4, wr_valid out 1, wr_ready in 1.
REQ-015 SHALL have read master ports rd_addr out 32, rd_byteEn out 4, rd_valid out 1, rd_ready in 1, rd_data in 32.

Function
REQ-016 SHALL latch all cmd_* fields on the cycle cmd_valid and cmd_ready are both high; cmd_ready = state IDLE.
REQ-017 SHALL implement FSM states IDLE, VB_WAIT_ACTIVE, VB_WAIT_BLANK, SET_X, SET_Y, FILL, FINISH.
REQ-018 From IDLE on accept: w==0 or h==0 -> FINISH, with no bus traffic; else cmd_vsync -> VB_WAIT_ACTIVE; else SET_X.
REQ-019 VB_WAIT_ACTIVE SHALL poll SCANLINE (VGA_ADDR+'h1c) until rd_data[9:0] != 0, then go to VB_WAIT_BLANK; VB_WAIT_BLANK SHALL poll until it reads 0, then go to SET_X.
REQ-020 SET_X SHALL write cmd_x to VGA_ADDR+'h04, then go to SET_Y.
REQ-021 SET_Y SHALL write the current row y to VGA_ADDR+'h08, then go to FILL.
REQ-022 FILL SHALL write cmd_color to VGA_ADDR+'h0c exactly w times, relying on the peripheral's x auto-increment.
REQ-023 After the w-th DATA write, FILL SHALL go to FINISH if abort was seen or the last row is done; otherwise it SHALL increment y and go to SET_X.
REQ-024 Every write SHALL use wr_byteEn=4'hF with wr_data zero-extended; every read SHALL use rd_byteEn=4'hF.
REQ-025 Handshake: SHALL hold addr, data and valid stable until ready is sampled high, then drop valid for at least the next cycle; at most one transaction is outstanding and reads and writes are never concurrent.
REQ-026 Clipping: effective w = min(w, MAX_W-x) and effective h = min(h, MAX_H-y), computed at accept; x>=MAX_W or y>=MAX_H SHALL be treated as zero size.
REQ-027 Row arithmetic SHALL use 12-bit intermediates so x+w and y+h never wrap.
REQ-028 abort SHALL be sticky until FINISH; an in-flight transaction SHALL complete, the current row SHALL finish, then the block goes to FINISH; abort in VB_WAIT_* SHALL go to FINISH after the outstanding read completes.
REQ-029 FINISH SHALL pulse done for one cycle, then go to IDLE; busy = state != IDLE.
REQ-030 A cmd_valid arriving while busy SHALL be held off with no effect on the active fill.

Reset
REQ-031 On reset, state SHALL become IDLE, and busy, done, wr_valid and rd_valid SHALL be 0; wr_addr, wr_data, rd_addr, wr_byteEn and rd_byteEn SHALL be 0; the abort latch SHALL clear.
REQ-032 Reset mid-transaction SHALL drop valid on the next edge with no completion wait.
REQ-033 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 x=10,y=20,w=3,h=2,color=5, vsync=0, ready=1 after one cycle -> writes X=10,Y=20,D×3,X=10,Y=21,D×3, then done is pulsed once.
REQ-035 w=0,h=7 -> done is pulsed 2 cycles after accept, with zero wr_valid.
REQ-036 MAX_W=640: x=638,w=10,h=1 -> exactly 2 DATA writes.
REQ-037 vsync=1, scanline sequence 0,0,5,6,0 -> the first X write starts only after the fifth read returns.
REQ-038 h=4, abort pulsed during row 1 with wr_ready stalled 5 cycles -> rows 0-1 complete, no row-2 writes, done is pulsed.
REQ-039 reset asserted while wr_valid=1 -> wr_valid=0, busy=0, cmd_ready=1 the next cycle.
